// File: rtl/framebuffer_multi.sv
// framebuffer_multi: 2- or 3-buffer framebuffer with a VSYNC-locked
// front swap and a hardware clear engine for each new back buffer.
module framebuffer_multi #(
    parameter int DATA_WIDTH  = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_BUFFERS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VSYNC,
    input  logic                  FRAME_DONE,
    input  logic                  RENDER_EN,
    input  logic [ADDR_WIDTH-1:0] RENDER_INDEX,
    input  logic [DATA_WIDTH-1:0] FB_IN,
    input  logic                  CLEAR_EN,
    input  logic [DATA_WIDTH-1:0] CLEAR_VALUE,
    input  logic [ADDR_WIDTH-1:0] addr_read,
    output logic [DATA_WIDTH-1:0] FB_OUT,
    output logic                  RENDER_READY,
    output logic                  SWAP_PENDING,
    output logic                  FRAME_DROP,
    output logic [1:0]            FRONT_SEL
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    generate
        if (NUM_BUFFERS != 2 && NUM_BUFFERS != 3) begin : g_bad_nb
            $error("framebuffer_multi: NUM_BUFFERS must be 2 or 3");
        end
    endgenerate

    typedef enum logic [1:0] {S_RENDER, S_WAIT_SWAP, S_CLEAR} state_t;

    state_t                r_state;
    logic [1:0]            r_front;
    logic [1:0]            r_back;
    logic [1:0]            r_ready;
    logic [1:0]            r_front_d;
    logic                  r_rv;
    logic                  r_drop;
    logic [ADDR_WIDTH:0]   r_clr;
    logic [DATA_WIDTH-1:0] r_clr_val;
    logic [DATA_WIDTH-1:0] r_mem [NUM_BUFFERS][DEPTH];
    logic [DATA_WIDTH-1:0] r_rd  [NUM_BUFFERS];

    state_t                w_state;
    logic [1:0]            w_front;
    logic [1:0]            w_back;
    logic [1:0]            w_ready;
    logic [1:0]            w_free;
    logic                  w_rv;
    logic                  w_drop;
    logic                  w_fd;
    logic                  w_clr_start;
    logic                  w_clearing;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_free     = 2'd3 - r_front - r_back;
    assign w_fd       = (r_state == S_RENDER) && FRAME_DONE;
    assign w_clearing = (r_state == S_CLEAR);

    always_comb begin
        w_state     = r_state;
        w_front     = r_front;
        w_back      = r_back;
        w_ready     = r_ready;
        w_rv        = r_rv;
        w_drop      = 1'b0;
        w_clr_start = 1'b0;
        if (w_clearing && r_clr == CLR_LAST) begin
            w_state = S_RENDER;
        end
        if (w_fd) begin
            w_ready = r_back;
            w_rv    = 1'b1;
            if (NUM_BUFFERS == 2) begin
                w_state = S_WAIT_SWAP;
            end else begin
                w_back      = r_rv ? r_ready : w_free;
                w_drop      = r_rv;
                w_clr_start = CLEAR_EN;
            end
        end
        // VSYNC sees the state as already updated by FRAME_DONE
        if (VSYNC && w_rv) begin
            w_front = w_ready;
            w_rv    = 1'b0;
            if (w_state == S_WAIT_SWAP) begin
                w_back      = r_front;
                w_state     = S_RENDER;
                w_clr_start = CLEAR_EN;
            end
        end
        if (w_clr_start) begin
            w_state = S_CLEAR;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state   <= S_RENDER;
            r_front   <= 2'd0;
            r_back    <= 2'd1;
            r_ready   <= 2'd0;
            r_front_d <= 2'd0;
            r_rv      <= 1'b0;
            r_drop    <= 1'b0;
            r_clr     <= '0;
            r_clr_val <= '0;
        end else begin
            r_state   <= w_state;
            r_front   <= w_front;
            r_back    <= w_back;
            r_ready   <= w_ready;
            r_front_d <= r_front;
            r_rv      <= w_rv;
            r_drop    <= w_drop;
            if (w_clr_start) begin
                r_clr     <= '0;
                r_clr_val <= CLEAR_VALUE;
            end else if (w_clearing) begin
                r_clr <= r_clr + 1'b1;
            end
        end
    end

    assign w_we    = RESET && ((r_state == S_RENDER && RENDER_EN) || w_clearing);
    assign w_waddr = w_clearing ? r_clr[ADDR_WIDTH-1:0] : RENDER_INDEX;
    assign w_wdata = w_clearing ? r_clr_val : FB_IN;

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (w_we && r_back == 2'(b)) begin
                r_mem[b][w_waddr] <= w_wdata;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (!RESET) begin
                r_rd[b] <= '0;
            end else begin
                r_rd[b] <= r_mem[b][addr_read];
            end
        end
    end

    // Select with the delayed index so data and selection swap together
    always_comb begin
        FB_OUT = '0;
        for (int b = 0; b < NUM_BUFFERS; b++) begin
            if (r_front_d == 2'(b)) begin
                FB_OUT = r_rd[b];
            end
        end
    end

    assign RENDER_READY = (r_state == S_RENDER);
    assign SWAP_PENDING = r_rv;
    assign FRAME_DROP   = r_drop;
    assign FRONT_SEL    = r_front;

    a_no_front_write: assert property (
        @(posedge CLK) !(w_we && r_back == r_front)
    );
endmodule

// File: tb/tb_framebuffer_multi.sv
// tb_framebuffer_multi: 2- and 3-buffer instances driven in lockstep
// and compared every cycle against a behavioural frame-swap model.
module tb_framebuffer_multi;
    localparam int MR = 0;
    localparam int MW = 1;
    localparam int MC = 2;

    logic       clk;
    logic       rst_n;
    logic       vsync;
    logic       fd;
    logic       ren;
    logic [3:0] ridx;
    logic [3:0] fbin;
    logic       cen;
    logic [3:0] cval;
    logic [3:0] raddr;

    logic [3:0] fb2, fb3;
    logic       rr2, rr3;
    logic       sp2, sp3;
    logic       dr2, dr3;
    logic [1:0] fs2, fs3;

    int n_tests = 0;
    int n_fail  = 0;

    int m_mem [2][3][16];
    int m_front [2];
    int m_back  [2];
    int m_ready [2];
    int m_rv    [2];
    int m_mode  [2];
    int m_clr   [2];
    int m_cval  [2];
    int m_fb    [2];
    int m_drop  [2];

    framebuffer_multi #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4), .NUM_BUFFERS(2)
    ) u_nb2 (
        .CLK(clk), .RESET(rst_n), .VSYNC(vsync), .FRAME_DONE(fd),
        .RENDER_EN(ren), .RENDER_INDEX(ridx), .FB_IN(fbin),
        .CLEAR_EN(cen), .CLEAR_VALUE(cval), .addr_read(raddr),
        .FB_OUT(fb2), .RENDER_READY(rr2), .SWAP_PENDING(sp2),
        .FRAME_DROP(dr2), .FRONT_SEL(fs2)
    );

    framebuffer_multi #(
        .DATA_WIDTH(4), .ADDR_WIDTH(4), .NUM_BUFFERS(3)
    ) u_nb3 (
        .CLK(clk), .RESET(rst_n), .VSYNC(vsync), .FRAME_DONE(fd),
        .RENDER_EN(ren), .RENDER_INDEX(ridx), .FB_IN(fbin),
        .CLEAR_EN(cen), .CLEAR_VALUE(cval), .addr_read(raddr),
        .FB_OUT(fb3), .RENDER_READY(rr3), .SWAP_PENDING(sp3),
        .FRAME_DROP(dr3), .FRONT_SEL(fs3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_clear(input int k);
        m_mode[k] = MC;
        m_clr[k]  = 0;
        m_cval[k] = int'(cval);
    endtask

    // One clock edge of the frame-swap rules for instance k
    task automatic model_step(input int k);
        int nb, rd, fda, nxt;
        nb = (k == 0) ? 2 : 3;
        rd = m_mem[k][m_front[k]][raddr];
        m_drop[k] = 0;
        if (!rst_n) begin
            m_front[k] = 0;
            m_back[k]  = 1;
            m_ready[k] = 0;
            m_rv[k]    = 0;
            m_mode[k]  = MR;
            m_fb[k]    = 0;
            return;
        end
        m_fb[k] = rd;
        fda = (m_mode[k] == MR && fd) ? 1 : 0;
        if (m_mode[k] == MR && ren)
            m_mem[k][m_back[k]][ridx] = int'(fbin);
        if (m_mode[k] == MC) begin
            m_mem[k][m_back[k]][m_clr[k]] = m_cval[k];
            m_clr[k]++;
            if (m_clr[k] == 16) m_mode[k] = MR;
        end
        if (fda != 0) begin
            if (nb == 2) begin
                m_ready[k] = m_back[k];
                m_rv[k]    = 1;
                m_mode[k]  = MW;
            end else begin
                if (m_rv[k] != 0) begin
                    nxt = m_ready[k];
                    m_drop[k] = 1;
                end else begin
                    nxt = 3 - m_front[k] - m_back[k];
                end
                m_ready[k] = m_back[k];
                m_rv[k]    = 1;
                m_back[k]  = nxt;
                if (cen) start_clear(k);
            end
        end
        if (vsync && m_rv[k] != 0) begin
            nxt = m_front[k];
            m_front[k] = m_ready[k];
            m_rv[k] = 0;
            if (m_mode[k] == MW) begin
                m_back[k] = nxt;
                m_mode[k] = MR;
                if (cen) start_clear(k);
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] fb;
        logic       r, s, d;
        logic [1:0] f;
        string      p;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                fb = fb2; r = rr2; s = sp2; d = dr2; f = fs2; p = "nb2";
            end else begin
                fb = fb3; r = rr3; s = sp3; d = dr3; f = fs3; p = "nb3";
            end
            check({p, ".ready"}, 32'(r), (m_mode[k] == MR) ? 1 : 0);
            check({p, ".pend"}, 32'(s), m_rv[k]);
            check({p, ".drop"}, 32'(d), m_drop[k]);
            check({p, ".front"}, 32'(f), m_front[k]);
            if (m_fb[k] >= 0)
                check({p, ".fbout"}, 32'(fb), m_fb[k]);
        end
    endtask

    task automatic cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        vsync = 0; fd = 0; ren = 0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < 3; b++)
                for (int a = 0; a < 16; a++)
                    m_mem[k][b][a] = -1;
            m_front[k] = 0; m_back[k] = 1; m_ready[k] = 0;
            m_rv[k] = 0; m_mode[k] = MR; m_clr[k] = 0;
            m_cval[k] = 0; m_fb[k] = -1; m_drop[k] = 0;
        end
        rst_n = 0; idle(); ridx = 0; fbin = 0;
        cen = 0; cval = 0; raddr = 0;

        // Reset state
        cycle(); cycle();
        check("rst.ready", 32'(rr3), 1);
        check("rst.front", 32'(fs3), 0);
        check("rst.fbout", 32'(fb3), 0);
        rst_n = 1;

        // Basic write, FRAME_DONE, VSYNC, read back
        raddr = 3;
        ren = 1; ridx = 3; fbin = 4'hA; cycle();
        ridx = 7; cycle();
        ren = 0; fd = 1; cycle();
        fd = 0;
        check("t1.pend2", 32'(sp2), 1);
        check("t1.pend3", 32'(sp3), 1);
        check("t1.ready2", 32'(rr2), 0);
        vsync = 1; cycle();
        vsync = 0;
        check("t1.pend3_clr", 32'(sp3), 0);
        check("t1.front3", 32'(fs3), 1);
        cycle();
        check("t1.fb2", 32'(fb2), 4'hA);
        check("t1.fb3", 32'(fb3), 4'hA);

        // Two-buffer stall until VSYNC
        fd = 1; cycle();
        fd = 0;
        check("t2.ready2", 32'(rr2), 0);
        check("t2.ready3", 32'(rr3), 1);
        ren = 1; ridx = 5; fbin = 4'h9;
        for (int i = 0; i < 3; i++) cycle();
        ren = 0; vsync = 1; cycle();
        vsync = 0;
        check("t2.ready2_back", 32'(rr2), 1);
        check("t2.front2", 32'(fs2), 0);
        raddr = 5; cycle();

        // Dropped frame on three buffers
        ren = 1; ridx = 0; fbin = 4'h1; cycle();
        ren = 0; fd = 1; cycle();
        fd = 0; ren = 1; fbin = 4'h2; cycle();
        ren = 0; fd = 1; cycle();
        fd = 0;
        check("t3.drop3", 32'(dr3), 1);
        cycle();
        check("t3.drop3_pulse", 32'(dr3), 0);
        vsync = 1; cycle();
        vsync = 0; raddr = 0; cycle();
        check("t3.fb3", 32'(fb3), 2);
        check("t3.fb2", 32'(fb2), 1);

        // Simultaneous swap with clear, 16-cycle clear window
        cen = 1; cval = 4'h5; raddr = 2;
        fd = 1; vsync = 1; cycle();
        idle(); cen = 0; cval = 4'h0;
        check("t4.front3", 32'(fs3), 0);
        check("t4.busy3_0", 32'(rr3), 0);
        for (int i = 1; i < 16; i++) begin
            cycle();
            check("t4.busy3", 32'(rr3), 0);
        end
        cycle();
        check("t4.done3", 32'(rr3), 1);
        check("t4.done2", 32'(rr2), 1);
        fd = 1; vsync = 1; cycle();
        idle();
        for (int a = 0; a < 16; a++) begin
            raddr = 4'(a);
            cycle();
            check("t4.clr2", 32'(fb2), 5);
            check("t4.clr3", 32'(fb3), 5);
        end

        // Reset in the middle of a clear
        cen = 1; cval = 4'h7; fd = 1; vsync = 1; cycle();
        idle(); cen = 0;
        for (int i = 0; i < 4; i++) cycle();
        check("t5.mid3", 32'(rr3), 0);
        rst_n = 0; cycle();
        rst_n = 1;
        check("t5.ready3", 32'(rr3), 1);
        check("t5.ready2", 32'(rr2), 1);
        check("t5.front3", 32'(fs3), 0);
        check("t5.pend3", 32'(sp3), 0);
        check("t5.fb3", 32'(fb3), 0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            vsync = ($urandom_range(0, 7) == 0);
            fd    = ($urandom_range(0, 9) == 0);
            ren   = ($urandom_range(0, 1) == 0);
            cen   = ($urandom_range(0, 3) == 0);
            ridx  = 4'($urandom);
            fbin  = 4'($urandom);
            cval  = 4'($urandom);
            raddr = 4'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
